ram16k_fill_ctrl: RTL
=====================

Name: ram16k_fill_ctrl

Overview:
Sequencer that sits directly upstream of student_ram16k and owns its in/load/address inputs.
- When idle, it passes CPU-side requests straight through to the RAM.
- On a start pulse, it takes the RAM for a burst fill of a contiguous address range with a constant or incrementing pattern. Typical uses: screen/RAM clear and test-pattern init.
- It then hands the port back and pulses done.

Parameters:
ADDR_W, 14, RAM address width (16384 words)
DATA_W, 16, word width
CNT_W, 15, fill-length width (0..16384 inclusive)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request a fill; sampled only in IDLE
base  in  ADDR_W  first fill address, sampled with start
count  in  CNT_W  number of words to write, sampled with start
pattern  in  DATA_W  fill seed, sampled with start
mode  in  1  0 = constant fill, 1 = incrementing (pattern+index), sampled with start
cpu_in  in  DATA_W  CPU write data
cpu_load  in  1  CPU write enable
cpu_address  in  ADDR_W  CPU address
ram_out  in  DATA_W  RAM read data (combinational from ram_address); used only with VERIFY_EN
ram_in  out  DATA_W  to RAM in
ram_load  out  1  to RAM load
ram_address  out  ADDR_W  to RAM address
cpu_stall  out  1  CPU request is being dropped
busy  out  1  controller owns the RAM
done  out  1  one-cycle completion pulse
err  out  1  sticky verify mismatch (VERIFY_EN only)
err_addr  out  ADDR_W  address of first mismatch (VERIFY_EN only)

Behaviour:
- States: IDLE, FILL, VERIFY (VERIFY_EN only).
- Reset (rst_n low, async):
  - state=IDLE; busy=0, done=0, cpu_stall=0, err=0, err_addr=0; internal index/address registers = 0.
  - ram_* outputs are the pass-through of cpu_*.
- IDLE:
  - ram_in=cpu_in, ram_load=cpu_load, ram_address=cpu_address, all combinational, zero added latency. busy=0, cpu_stall=0.
  - start=1 at a clock edge latches base/count/pattern/mode and clears err/err_addr.
    - count!=0: go to FILL.
    - count==0: stay in IDLE with done=1 for the next cycle and no writes.
- FILL:
  - busy=1, ram_load=1, ram_address=(base+idx) mod 2^ADDR_W.
  - ram_in = pattern (mode 0), or (pattern+idx) mod 2^DATA_W (mode 1).
  - idx runs 0..count-1, one write per cycle; the write commits at the edge ending the cycle.
  - After the cycle with idx=count-1, go to VERIFY (if compiled in) or IDLE.
- Exit:
  - The first cycle back in IDLE has done=1 for exactly one cycle.
  - A fill of N words keeps busy high for exactly N cycles (2N with verify).
- Address wrap: base+idx past 16383 wraps to 0. count=16384 writes every word exactly once.
- CPU side while busy:
  - cpu_stall = cpu_load (the request is dropped, never queued); the RAM never sees cpu_*.
  - CPU reads during busy observe fill addresses.
- start while busy: ignored.
- start in the same cycle as done: accepted; the new fill begins next cycle.
- Reset mid-FILL: immediate return to IDLE; already-written words stay written; no done pulse.

Optional Feature:
Macro VERIFY_EN.
- Defined:
  - After FILL, the VERIFY state re-sweeps the same range, idx 0..count-1, with ram_load=0 and the same addresses.
  - Each cycle, ram_out is compared with the expected data for that idx.
  - On the first mismatch: err=1 and err_addr=address. The sweep continues to the end.
  - err stays set until the next accepted start or reset.
- Undefined: no VERIFY state; err and err_addr are tied 0; ram_out is ignored.

Decomposition:
- Package hack_mem_pkg:
  - ADDR_W, DATA_W, CNT_W, RAM_WORDS=16384.
  - State enum typedef fill_state_t {IDLE, FILL, VERIFY}.
  - Mode constants MODE_CONST=0, MODE_INC=1.
- Sub-module fill_addr_gen: idx counter with load/step/last flag, wrapped address adder, and pattern data generator. It is reused by both FILL and VERIFY.

Test Plan:
- IDLE pass-through:
  - Stimulus: cpu_load=1, cpu_address=0x0123, cpu_in=0xBEEF, then read 0x0123.
  - Required: ram_out=0xBEEF; busy=0, cpu_stall=0.
- Constant fill:
  - Stimulus: base=0x0100, count=4, pattern=0xA5A5, mode=0.
  - Required: busy high 4 cycles; 0x0100..0x0103 = 0xA5A5; 0x00FF and 0x0104 unchanged; done one cycle after the last write.
- Incrementing fill with wrap:
  - Stimulus: base=0x3FFE, count=4, pattern=0xFFFE, mode=1.
  - Required: 0x3FFE=0xFFFE, 0x3FFF=0xFFFF, 0x0000=0x0000, 0x0001=0x0001.
- Zero count and busy start:
  - Stimulus: count=0.
  - Required: done next cycle, no ram_load, busy never asserted.
  - Stimulus: start pulsed mid-fill.
  - Required: ignored; the original fill completes unchanged.
- CPU contention and reset:
  - Stimulus: cpu_load=1 to 0x0200 during a fill of 0x0000..0x00FF.
  - Required: cpu_stall=1 and 0x0200 unchanged.
  - Stimulus: rst_n low mid-fill.
  - Required: outputs go to reset values immediately, done=0, partial writes remain.
- VERIFY_EN:
  - Stimulus: RAM model forced to corrupt address 0x0102 after a fill of base=0x0100, count=4.
  - Required: err=1, err_addr=0x0102, busy for 8 cycles; err clears on the next start.

Source files
------------

// File: rtl/ram16k_fill_ctrl_pkg.sv
// Shared widths, FSM state type and fill-mode encodings for the RAM16K fill sequencer.
package hack_mem_pkg;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 16;
    localparam int CNT_W     = 15;
    localparam int RAM_WORDS = 16384;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        VERIFY = 2'd2
    } fill_state_t;

    localparam logic MODE_CONST = 1'b0;
    localparam logic MODE_INC   = 1'b1;

endpackage

// File: rtl/ram16k_fill_ctrl_if.sv
// Bundle of the fill-request, CPU-side and RAM-side signals around ram16k_fill_ctrl.
// The slave modport is the controller; the master modport is its environment (CPU + RAM).
interface ram16k_fill_ctrl_if;
    import hack_mem_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] pattern;
    logic              mode;
    logic [DATA_W-1:0] cpu_in;
    logic              cpu_load;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_stall;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_out;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    modport master (
        output start, base, count, pattern, mode, cpu_in, cpu_load, cpu_address, ram_out,
        input  ram_in, ram_load, ram_address, cpu_stall, busy, done, err, err_addr
    );

    modport slave (
        input  start, base, count, pattern, mode, cpu_in, cpu_load, cpu_address, ram_out,
        output ram_in, ram_load, ram_address, cpu_stall, busy, done, err, err_addr
    );

endinterface

// File: rtl/ram16k_fill_ctrl_addr_gen.sv
// Fill index counter plus wrapped address and pattern generators; shared by the write
// sweep and the optional read-back sweep of ram16k_fill_ctrl.
module fill_addr_gen
    import hack_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [CNT_W-1:0]  i_count,
    input  logic [DATA_W-1:0] i_pattern,
    input  logic              i_mode,
    input  logic              i_restart,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_pattern;
    logic              r_mode;
    logic [CNT_W-1:0]  r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base    <= '0;
            r_count   <= '0;
            r_pattern <= '0;
            r_mode    <= MODE_CONST;
            r_idx     <= '0;
        end else if (i_load) begin
            r_base    <= i_base;
            r_count   <= i_count;
            r_pattern <= i_pattern;
            r_mode    <= i_mode;
            r_idx     <= '0;
        end else if (i_restart) begin
            r_idx <= '0;
        end else if (i_step) begin
            r_idx <= r_idx + CNT_W'(1);
        end
    end

    // Address and data wrap naturally by truncation to their port widths.
    assign o_addr = r_base + r_idx[ADDR_W-1:0];
    assign o_data = (r_mode == MODE_INC) ? (r_pattern + DATA_W'(r_idx)) : r_pattern;
    assign o_last = (r_idx == (r_count - CNT_W'(1)));

endmodule

// File: rtl/ram16k_fill_ctrl.sv
// Burst-fill sequencer in front of student_ram16k: CPU pass-through when idle, owns the RAM
// during a fill. Define VERIFY_EN to add a read-back sweep with sticky mismatch reporting.
module ram16k_fill_ctrl
    import hack_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    ram16k_fill_ctrl_if.slave   bus
);

    fill_state_t       r_state;
    logic              r_busy;
    logic              r_done;
    logic              w_load;
    logic              w_step;
    logic              w_restart;
    logic              w_last;
    logic [ADDR_W-1:0] w_gen_addr;
    logic [DATA_W-1:0] w_gen_data;

    assign w_load = (r_state == IDLE) && bus.start;
    assign w_step = (r_state != IDLE);

`ifdef VERIFY_EN
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;
    assign w_restart = (r_state == FILL) && w_last;
`else
    logic w_unused_ram_out;
    assign w_unused_ram_out = ^bus.ram_out;
    assign w_restart        = 1'b0;
`endif

    fill_addr_gen u_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_base    (bus.base),
        .i_count   (bus.count),
        .i_pattern (bus.pattern),
        .i_mode    (bus.mode),
        .i_restart (w_restart),
        .i_step    (w_step),
        .o_addr    (w_gen_addr),
        .o_data    (w_gen_data),
        .o_last    (w_last)
    );

    // A zero-length request never leaves IDLE but still earns its done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef VERIFY_EN
            r_err      <= 1'b0;
            r_err_addr <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
`ifdef VERIFY_EN
                        r_err      <= 1'b0;
                        r_err_addr <= '0;
`endif
                        if (bus.count != '0) begin
                            r_state <= FILL;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (w_last) begin
`ifdef VERIFY_EN
                        r_state <= VERIFY;
`else
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end
                end
`ifdef VERIFY_EN
                VERIFY: begin
                    if ((bus.ram_out != w_gen_data) && !r_err) begin
                        r_err      <= 1'b1;
                        r_err_addr <= w_gen_addr;
                    end
                    if (w_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // CPU requests made while the controller owns the RAM are dropped, not queued.
    assign bus.ram_load    = (r_state == FILL) ? 1'b1 :
                             (r_state == IDLE) ? bus.cpu_load : 1'b0;
    assign bus.ram_address = (r_state == IDLE) ? bus.cpu_address : w_gen_addr;
    assign bus.ram_in      = (r_state == IDLE) ? bus.cpu_in : w_gen_data;
    assign bus.cpu_stall   = r_busy & bus.cpu_load;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

`ifdef VERIFY_EN
    assign bus.err      = r_err;
    assign bus.err_addr = r_err_addr;
`else
    assign bus.err      = 1'b0;
    assign bus.err_addr = '0;
`endif

endmodule
